// File: rtl/map_port_arbiter_if.sv
// Map RAM port-B access bus shared by the three sprite requesters and the arbiter.
// The master side (requesters + RAM model) drives requests and read data; the slave is the arbiter.
interface map_port_arbiter_if;
    logic [2:0]   req;
    logic [17:0]  req_x;
    logic [14:0]  req_y;
    logic [11:0]  req_tile;
    logic [2:0]   grant;
    logic [2:0]   done;
    logic [3:0]   old_tile;
    logic         err;
    logic         busy;
    logic [4:0]   wraddr;
    logic [159:0] wrdata;
    logic         wren;
    logic [159:0] redata;

    modport master (
        output req, req_x, req_y, req_tile, redata,
        input  grant, done, old_tile, err, busy, wraddr, wrdata, wren
    );

    modport slave (
        input  req, req_x, req_y, req_tile, redata,
        output grant, done, old_tile, err, busy, wraddr, wrdata, wren
    );
endinterface

// File: rtl/map_port_arbiter.sv
// Round-robin arbiter giving pacman and two ghosts read-modify-write access to one map tile
// through map RAM port B (read a 40-tile row, replace one nibble, write it back).
module map_port_arbiter #(
    parameter int RD_LAT   = 2,
    parameter int MAP_COLS = 40,
    parameter int MAP_ROWS = 30
) (
    input logic             CLOCK_50,
    input logic             reset,
    map_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state;
    logic [1:0]  last;      // index granted most recently; search starts after it
    logic [1:0]  win_q;
    logic [5:0]  x_q;
    logic [3:0]  tile_q;
    logic [3:0]  rd_nib_q;
    logic [7:0]  cnt;

    logic        any;
    logic [1:0]  win;
    logic [5:0]  win_x;
    logic [4:0]  win_y;
    logic [3:0]  win_tile;
    logic        legal;
    logic [7:0]  nib_lo;
    logic [159:0] new_word;

    always_comb begin
        any = 1'b0;
        win = last;
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (int'(last) + k) % 3;
            if (!any && bus.req[idx]) begin
                any = 1'b1;
                win = 2'(idx);
            end
        end
    end

    assign win_x    = bus.req_x[6*win +: 6];
    assign win_y    = bus.req_y[5*win +: 5];
    assign win_tile = bus.req_tile[4*win +: 4];
    assign legal    = (int'(win_x) < MAP_COLS) && (int'(win_y) < MAP_ROWS);

    // x=0 is the most significant nibble of the row word
    assign nib_lo = 8'(156 - 4 * int'(x_q));

    always_comb begin
        new_word = bus.redata;
        new_word[nib_lo +: 4] = tile_q;
    end

    assign bus.busy = (state != IDLE);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state        <= IDLE;
            last         <= 2'd2;
            win_q        <= '0;
            x_q          <= '0;
            tile_q       <= '0;
            rd_nib_q     <= '0;
            cnt          <= '0;
            bus.grant    <= '0;
            bus.done     <= '0;
            bus.err      <= 1'b0;
            bus.old_tile <= '0;
            bus.wraddr   <= '0;
            bus.wrdata   <= '0;
            bus.wren     <= 1'b0;
        end else begin
            bus.grant <= '0;
            bus.done  <= '0;
            bus.err   <= 1'b0;
            bus.wren  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        last      <= win;
                        bus.grant <= 3'b001 << win;
                        if (legal) begin
                            win_q      <= win;
                            x_q        <= win_x;
                            tile_q     <= win_tile;
                            bus.wraddr <= win_y;
                            cnt        <= '0;
                            state      <= READ;
                        end else begin
                            bus.err <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (cnt == 8'(RD_LAT - 1)) begin
                        rd_nib_q   <= bus.redata[nib_lo +: 4];
                        bus.wrdata <= new_word;
                        bus.wren   <= 1'b1;
                        state      <= WRITE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WRITE: begin
                    bus.done     <= 3'b001 << win_q;
                    bus.old_tile <= rd_nib_q;
                    state        <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/map_port_arbiter.md
MAP_PORT_ARBITER -- requirements
Module: map_port_arbiter

Interface
REQ-001 Parameter RD_LAT, default 2: map RAM port-B read latency in cycles, from address presented to redata valid.
REQ-002 Parameter MAP_COLS, default 40: tiles per map row; legal x range is 0..MAP_COLS-1.
REQ-003 Parameter MAP_ROWS, default 30: map rows; legal y range is 0..MAP_ROWS-1.
REQ-004 CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 req  in  3  request per requester: bit0 pacman, bit1 ghost1, bit2 ghost2.
REQ-007 req_x  in  18  packed tile x per requester, 6 bits each; requester i uses [6i+5:6i].
REQ-008 req_y  in  15  packed tile y per requester, 5 bits each; requester i uses [5i+4:5i].
REQ-009 req_tile  in  12  packed new 4-bit tile code per requester; requester i uses [4i+3:4i].
REQ-010 grant  out  3  one-hot, one-cycle pulse when a request is accepted.
REQ-011 done  out  3  one-hot, one-cycle pulse when the accepted write has completed.
REQ-012 old_tile  out  4  tile code that was replaced by the last completed access.
REQ-013 err  out  1  one-cycle pulse that rejects an out-of-range request.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.
REQ-015 wraddr  out  5  map RAM port-B row address.
REQ-016 wrdata  out  160  map RAM port-B write word.
REQ-017 wren  out  1  map RAM port-B write enable.
REQ-018 redata  in  160  map RAM port-B read word.

Function
REQ-019 FSM states SHALL be IDLE, READ, WRITE and DONE.
REQ-020 IDLE SHALL leave for READ at edge E0 when any req bit is 1 and the winner's coordinates are legal.
REQ-021 Arbitration SHALL be round-robin: the search starts at the bit after the last granted index, modulo 3.
REQ-022 The arbitration pointer SHALL advance to the winner on every grant, including rejected grants.
REQ-023 At E0 the block SHALL latch winner index, x, y and tile code, then assert grant[winner] for the following cycle only.
REQ-024 wraddr SHALL equal the latched y from the cycle after E0 until the block returns to IDLE.
REQ-025 READ SHALL last RD_LAT cycles; redata SHALL be captured at edge E0+RD_LAT, and the FSM SHALL enter WRITE.
REQ-026 Tile nibble position: x occupies bits [156-4x+3:156-4x], so x=0 maps to bits 159:156 and x=39 maps to bits 3:0.
REQ-027 In WRITE, for exactly one cycle: wren=1; wrdata = captured word with only the addressed nibble replaced by the latched tile code; the other 156 bits unchanged.
REQ-028 At edge E0+RD_LAT+1 the FSM SHALL enter DONE, with done[winner]=1 for one cycle and old_tile loaded with the replaced nibble.
REQ-029 old_tile SHALL hold its value until the next completed access.
REQ-030 DONE SHALL return to IDLE on the next edge.
REQ-031 Earliest next grant is edge E0+RD_LAT+3, giving throughput of one access per RD_LAT+3 cycles.
REQ-032 req bits arriving while busy SHALL remain pending and SHALL NOT be dropped.
REQ-033 A requester SHALL hold req and its fields until its grant pulse, and SHALL deassert req before its done pulse.
REQ-034 A winner with x>=MAP_COLS or y>=MAP_ROWS SHALL be rejected: grant[winner] and err pulse together for one cycle; no RAM access; no done; FSM stays IDLE.
REQ-035 Simultaneous requests SHALL be resolved by the round-robin pointer only; there SHALL be no fixed priority beyond the reset pointer.
REQ-036 wren SHALL be 0 in every state except WRITE.
REQ-037 grant, done and err SHALL never assert in the same cycle, except grant with err on a rejection.

Reset
REQ-038 While reset=1 on an edge, the next cycle SHALL show: state IDLE, grant=0, done=0, err=0, busy=0, wren=0, wraddr=0, wrdata=0, old_tile=0.
REQ-039 Reset SHALL set the pointer so that bit0 (pacman) has highest priority on the first arbitration.
REQ-040 Reset in READ or WRITE SHALL abort the access: no further wren and no done for that access.

Verification
REQ-041 Single access: RD_LAT=2; req=001, x=0, y=3, tile=4; redata=160'h1..1 -> grant=001 at cycle 1; wraddr=3; wren one cycle at cycle 3 with wrdata[159:156]=4 and the rest unchanged; done=001 at cycle 4; old_tile=1.
REQ-042 Fairness: req=111 held continuously -> grant order 001, 010, 100, 001, with a 5-cycle spacing between grants.
REQ-043 Boundary: x=39, tile=F on a zero word -> wrdata=160'hF; x=40 -> grant and err pulse together, wren stays 0, busy stays 0.
REQ-044 Pending request: req=010 asserted mid-access of requester 0 -> req=010 is granted at the first IDLE edge after done=001.
REQ-045 Abort: reset asserted during READ -> wren and done both stay 0; the next req=100 is granted normally with the pointer at bit0 priority.
